// File: rtl/mem_byte_responder.sv
// mem_byte_responder: FIFO-backed byte source answering the stop/ok handshake
// and the single-byte mr_ memory read of the byte-fetch unit.
//
// Handshake: the reader raises stop to request a byte. When the FIFO holds
// one, ok rises on the next edge with the head byte on d7_d0, held stable
// while ok=1. A low-then-high pulse on mr_ during the offer consumes the byte:
// the FIFO pops on the mr_ rising edge. ok falls one edge after stop falls.
// If stop falls before any mr_ rise, the offer is withdrawn and the byte is kept.
//
// Optional build macro ADDR_CHECK_EN: tracks the expected read address and
// raises the sticky err flag when the reader presents a different one.
module mem_byte_responder #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    input  logic                  stop,
    input  logic                  mr_,
    input  logic [23:0]           a23_a0,
    output logic                  ok,
    output logic [7:0]            d7_d0,
    output logic                  err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_d;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  mr_q;
    logic                  fall;
    logic                  rise;
    logic                  push;
    logic                  pop;
    logic                  ok_d;
    logic [7:0]            data_d;

    assign full = (level == (DEPTH_LOG2+1)'(DEPTH));
    assign fall = mr_q & ~mr_;
    assign rise = ~mr_q & mr_;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // accepted when it coincides with a pop.
    assign push = wr_en & (~full | pop);

    // Next-state, offer and pop decisions for the responder FSM.
    always_comb begin
        state_d = state;
        ok_d    = ok;
        data_d  = d7_d0;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (stop && (level != '0)) begin
                    data_d  = mem[rd_ptr];
                    ok_d    = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (rise) begin
                    pop     = 1'b1;
                    state_d = DONE;
                end else if (!stop) begin
                    ok_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (!stop) begin
                    ok_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ok_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, offered byte and mr_ edge-detect register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            ok    <= 1'b0;
            d7_d0 <= 8'h00;
            mr_q  <= 1'b1;
        end else begin
            state <= state_d;
            ok    <= ok_d;
            d7_d0 <= data_d;
            mr_q  <= mr_;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({push, pop})
                2'b10:   level <= level + (DEPTH_LOG2+1)'(1);
                2'b01:   level <= level - (DEPTH_LOG2+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // FIFO storage; needs no reset because the pointers define validity.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

`ifdef ADDR_CHECK_EN
    logic [23:0] exp_addr;

    // Expected-address tracking: compare on the mr_ fall of an offer,
    // advance on every pop, err is sticky until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            exp_addr <= 24'h000000;
            err      <= 1'b0;
        end else begin
            if ((state == OFFER) && fall && (a23_a0 != exp_addr)) err <= 1'b1;
            if (pop) exp_addr <= exp_addr + 24'd1;
        end
    end
`else
    // Without the address check the address bus and fall detector are unused.
    logic unused_addr;
    assign unused_addr = ^{a23_a0, fall};
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_mem_byte_responder.sv
// Self-checking bench for mem_byte_responder. Inputs are driven and outputs
// sampled on the falling clock edge. Expected bytes live in exp_q, pushed
// when the producer write is accepted and popped when a transfer completes.
module tb_mem_byte_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        full;
    logic [4:0]  level;
    logic        stop;
    logic        mr_;
    logic [23:0] a23_a0;
    logic        ok;
    logic [7:0]  d7_d0;
    logic        err;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp_q[$];
    int          m_level;
    logic        m_err;
    logic [23:0] m_exp;

    always #5 clock = ~clock;

    mem_byte_responder #(.DEPTH_LOG2(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .level   (level),
        .stop    (stop),
        .mr_     (mr_),
        .a23_a0  (a23_a0),
        .ok      (ok),
        .d7_d0   (d7_d0),
        .err     (err)
    );

    function automatic logic exp_err();
`ifdef ADDR_CHECK_EN
        return m_err;
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic apply_reset();
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
        stop = 1'b0; mr_ = 1'b1; a23_a0 = 24'h0;
        cyc(2);
        reset = 1'b0;
        exp_q.delete();
        m_level = 0; m_err = 1'b0; m_exp = 24'h0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr_en = 1'b1; wr_data = b;
        cyc(1);
        wr_en = 1'b0;
        if (m_level < 16) begin
            exp_q.push_back(b);
            m_level++;
        end
    endtask

    task automatic pulse_mr(input logic [23:0] addr);
        a23_a0 = addr; mr_ = 1'b0;
        cyc(1);
        mr_ = 1'b1;
        cyc(1);
    endtask

    task automatic wait_ok(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ok === 1'b1) begin
                got = 1'b1;
                break;
            end
            cyc(1);
        end
    endtask

    // Full transfer: request, wait for the offer, read it, release stop.
    task automatic read_byte(input logic [23:0] addr, output logic [7:0] data, output bit got);
        stop = 1'b1;
        wait_ok(got);
        data = d7_d0;
        if (got) begin
            pulse_mr(addr);
            if (addr != m_exp) m_err = 1'b1;
            m_exp = m_exp + 24'd1;
            m_level--;
        end
        stop = 1'b0;
        cyc(1);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL reset_ok: got %b expected 0", ok); end
        checks++; if (d7_d0 !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", d7_d0); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    endtask

    task automatic test_basic();
        logic [7:0] exp_b;
        push_byte(8'hA5);
        checks++; if (level !== 5'(m_level)) begin errors++; $display("FAIL basic_level_push: got %0d expected %0d", level, m_level); end
        stop = 1'b1;
        cyc(1);
        exp_b = exp_q[0];
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_ok_latency: got %b expected 1", ok); end
        checks++; if (d7_d0 !== exp_b) begin errors++; $display("FAIL basic_data: got %h expected %h", d7_d0, exp_b); end
        pulse_mr(m_exp);
        void'(exp_q.pop_front());
        m_exp = m_exp + 24'd1; m_level--;
        checks++; if (level !== 5'(m_level)) begin errors++; $display("FAIL basic_level_pop: got %0d expected %0d", level, m_level); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_ok_done: got %b expected 1", ok); end
        checks++; if (d7_d0 !== exp_b) begin errors++; $display("FAIL basic_data_held: got %h expected %h", d7_d0, exp_b); end
        stop = 1'b0;
        cyc(1);
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL basic_ok_drop: got %b expected 0", ok); end
    endtask

    task automatic test_empty_wait();
        stop = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            checks++; if (ok !== 1'b0) begin errors++; $display("FAIL empty_ok_cycle%0d: got %b expected 0", i, ok); end
        end
        wr_en = 1'b1; wr_data = 8'h3C;
        cyc(1);
        wr_en = 1'b0;
        exp_q.push_back(8'h3C); m_level++;
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL empty_ok_first_edge: got %b expected 0", ok); end
        cyc(1);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL empty_ok_second_edge: got %b expected 1", ok); end
        checks++; if (d7_d0 !== exp_q[0]) begin errors++; $display("FAIL empty_data: got %h expected %h", d7_d0, exp_q[0]); end
        pulse_mr(m_exp);
        void'(exp_q.pop_front());
        m_exp = m_exp + 24'd1; m_level--;
        stop = 1'b0;
        cyc(1);
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL empty_ok_drop: got %b expected 0", ok); end
    endtask

    task automatic test_fill_drain();
        logic [7:0] d;
        logic [7:0] exp_b;
        bit         got;
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", full); end
        push_byte(8'd16);
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL fill_level_overflow: got %0d expected 16", level); end
        for (int i = 0; i < 16; i++) begin
            read_byte(m_exp, d, got);
            checks++;
            if (!got) begin
                errors++; $display("FAIL drain_timeout%0d: got no ok expected ok=1", i);
            end else begin
                exp_b = exp_q.pop_front();
                if (d !== exp_b) begin errors++; $display("FAIL drain_data%0d: got %h expected %h", i, d, exp_b); end
            end
            checks++; if (ok !== 1'b0) begin errors++; $display("FAIL drain_ok_drop%0d: got %b expected 0", i, ok); end
        end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL drain_level: got %0d expected 0", level); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL drain_leftover: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_abort_reoffer();
        logic [7:0] d;
        logic [7:0] exp_b;
        bit         got;
        push_byte(8'h77);
        push_byte(8'h78);
        stop = 1'b1;
        wait_ok(got);
        checks++; if (!got || d7_d0 !== exp_q[0]) begin errors++; $display("FAIL abort_offer: got ok=%b data=%h expected ok=1 data=%h", ok, d7_d0, exp_q[0]); end
        stop = 1'b0;
        cyc(1);
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL abort_ok_drop: got %b expected 0", ok); end
        checks++; if (level !== 5'(m_level)) begin errors++; $display("FAIL abort_level: got %0d expected %0d", level, m_level); end
        pulse_mr(m_exp);
        checks++; if (level !== 5'(m_level)) begin errors++; $display("FAIL idle_mr_ignored: got %0d expected %0d", level, m_level); end
        stop = 1'b1;
        wait_ok(got);
        checks++; if (!got || d7_d0 !== exp_q[0]) begin errors++; $display("FAIL reoffer_data: got ok=%b data=%h expected ok=1 data=%h", ok, d7_d0, exp_q[0]); end
        pulse_mr(m_exp);
        void'(exp_q.pop_front());
        m_exp = m_exp + 24'd1; m_level--;
        checks++; if (level !== 5'(m_level)) begin errors++; $display("FAIL reoffer_pop: got %0d expected %0d", level, m_level); end
        pulse_mr(m_exp);
        checks++; if (level !== 5'(m_level)) begin errors++; $display("FAIL done_second_pulse: got %0d expected %0d", level, m_level); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL done_ok_held: got %b expected 1", ok); end
        stop = 1'b0;
        cyc(1);
        read_byte(m_exp, d, got);
        checks++;
        if (!got) begin
            errors++; $display("FAIL abort_tail_timeout: got no ok expected ok=1");
        end else begin
            exp_b = exp_q.pop_front();
            if (d !== exp_b) begin errors++; $display("FAIL abort_tail_data: got %h expected %h", d, exp_b); end
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] d;
        logic [7:0] exp_b;
        logic [7:0] extra;
        bit         got;
        for (int i = 0; i < 16; i++) push_byte(8'($urandom_range(0, 255)));
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fpp_full: got %b expected 1", full); end
        stop = 1'b1;
        wait_ok(got);
        checks++; if (!got || d7_d0 !== exp_q[0]) begin errors++; $display("FAIL fpp_offer: got ok=%b data=%h expected ok=1 data=%h", ok, d7_d0, exp_q[0]); end
        extra = 8'($urandom_range(0, 255));
        a23_a0 = m_exp; mr_ = 1'b0;
        cyc(1);
        mr_ = 1'b1; wr_en = 1'b1; wr_data = extra;
        cyc(1);
        wr_en = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(extra);
        m_exp = m_exp + 24'd1;
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL fpp_level: got %0d expected 16", level); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fpp_full_after: got %b expected 1", full); end
        stop = 1'b0;
        cyc(1);
        for (int i = 0; i < 16; i++) begin
            read_byte(m_exp, d, got);
            checks++;
            if (!got) begin
                errors++; $display("FAIL fpp_drain_timeout%0d: got no ok expected ok=1", i);
            end else begin
                exp_b = exp_q.pop_front();
                if (d !== exp_b) begin errors++; $display("FAIL fpp_drain_data%0d: got %h expected %h", i, d, exp_b); end
            end
        end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL fpp_level_end: got %0d expected 0", level); end
    endtask

    task automatic test_reset_mid();
        bit got;
        push_byte(8'h5A);
        stop = 1'b1;
        wait_ok(got);
        checks++; if (!got) begin errors++; $display("FAIL mid_offer: got ok=%b expected 1", ok); end
        reset = 1'b1;
        cyc(1);
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL mid_reset_ok: got %b expected 0", ok); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL mid_reset_level: got %0d expected 0", level); end
        stop = 1'b0;
        apply_reset();
    endtask

    task automatic test_addr_check();
        logic [23:0] addrs [3];
        logic [7:0]  d;
        logic [7:0]  exp_b;
        bit          got;
        addrs[0] = 24'd0; addrs[1] = 24'd1; addrs[2] = 24'd5;
        apply_reset();
        for (int i = 0; i < 3; i++) push_byte(8'h40 + 8'(i));
        for (int i = 0; i < 3; i++) begin
            read_byte(addrs[i], d, got);
            checks++;
            if (!got) begin
                errors++; $display("FAIL addr_timeout%0d: got no ok expected ok=1", i);
            end else begin
                exp_b = exp_q.pop_front();
                if (d !== exp_b) begin errors++; $display("FAIL addr_data%0d: got %h expected %h", i, d, exp_b); end
            end
            checks++; if (err !== exp_err()) begin errors++; $display("FAIL addr_err%0d: got %b expected %b", i, err, exp_err()); end
        end
        cyc(5);
        checks++; if (err !== exp_err()) begin errors++; $display("FAIL addr_err_sticky: got %b expected %b", err, exp_err()); end
        apply_reset();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL addr_err_reset: got %b expected 0", err); end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
        stop = 1'b0; mr_ = 1'b1; a23_a0 = 24'h0;
        test_reset();
        test_basic();
        test_empty_wait();
        test_fill_drain();
        test_abort_reoffer();
        test_full_push_pop();
        test_reset_mid();
        test_addr_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
